// File: rtl/mem_bus_master_pkg.sv
// rtl/mem_bus_master_pkg.sv - shared state encoding and memory-map constants
package mem_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam int          HOLD_CYCLES_DEFAULT = 4;
   localparam logic [15:0] RAM_BASE            = 16'h8000;
   localparam logic [15:0] IO_BASE             = 16'hffe4;

endpackage

// File: rtl/mem_bus_master_bus_hold_timer.sv
// rtl/mem_bus_master_bus_hold_timer.sv - per-byte bus hold counter
module bus_hold_timer #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);

   logic [3:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= 4'd0;
      end else if (en) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign done = (cnt == LAST);

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - 8/16-bit request to held byte-access bus initiator
module mem_bus_master
   import mem_bus_master_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_we,
   input  logic        req_word,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        ack,
   output logic [15:0] rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_write_en,
   input  logic [7:0]  mem_rdata
);

   state_t     state;
   logic       r_we;
   logic       r_word;
   logic [7:0] r_wdata_hi;
   logic       hold_done;
   logic       holding;
   logic       timer_load;

   assign holding    = (state == ST_LO) || (state == ST_HI);
   // Restart the count on acceptance and at every byte boundary so HI gets a full hold.
   assign timer_load = ((state == ST_IDLE) && req) || (holding && hold_done);

   bus_hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_timer (
      .clk  (clk),
      .reset(reset),
      .load (timer_load),
      .en   (holding),
      .done (hold_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         ack          <= 1'b0;
         rdata        <= 16'h0000;
         mem_addr     <= 16'h0000;
         mem_wdata    <= 8'h00;
         mem_write_en <= 1'b0;
         r_we         <= 1'b0;
         r_word       <= 1'b0;
         r_wdata_hi   <= 8'h00;
      end else begin
         ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  r_we         <= req_we;
                  r_word       <= req_word;
                  r_wdata_hi   <= req_wdata[15:8];
                  mem_addr     <= req_addr;
                  mem_wdata    <= req_wdata[7:0];
                  mem_write_en <= req_we;
                  busy         <= 1'b1;
                  state        <= ST_LO;
               end
            end
            ST_LO: begin
               if (hold_done) begin
                  if (!r_we) begin
                     rdata[7:0] <= mem_rdata;
                     if (!r_word) begin
                        rdata[15:8] <= 8'h00;
                     end
                  end
                  if (r_word) begin
                     // 16-bit wrap is intentional: 0xffff continues at 0x0000.
                     mem_addr  <= mem_addr + 16'd1;
                     mem_wdata <= r_wdata_hi;
                     state     <= ST_HI;
                  end else begin
                     mem_write_en <= 1'b0;
                     ack          <= 1'b1;
                     state        <= ST_RESP;
                  end
               end
            end
            ST_HI: begin
               if (hold_done) begin
                  if (!r_we) begin
                     rdata[15:8] <= mem_rdata;
                  end
                  mem_write_en <= 1'b0;
                  ack          <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            ST_RESP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard bench with a byte-wide responder model
module tb_mem_bus_master;

   localparam int H = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        req_we;
   logic        req_word;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        busy;
   logic        ack;
   logic [15:0] rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_write_en;
   logic [7:0]  mem_rdata;

   always #5 clk = ~clk;

   mem_bus_master #(.HOLD_CYCLES(H)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_we      (req_we),
      .req_word    (req_word),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .busy        (busy),
      .ack         (ack),
      .rdata       (rdata),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_write_en(mem_write_en),
      .mem_rdata   (mem_rdata)
   );

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i) ^ 8'(i >> 8) ^ 8'h3c;
   endfunction

   // Responder: ROM below 0x8000, RAM/IO above, write cooldown of H clocks.
   logic [7:0] mem [0:65535];
   int         wcount [0:65535];
   int         cool;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]    = init_byte(i);
         wcount[i] = 0;
      end
      cool = 0;
      forever begin
         @(posedge clk);
         if (cool > 0) begin
            cool = cool - 1;
         end else if (mem_write_en === 1'b1) begin
            if (mem_addr >= 16'h8000) mem[mem_addr] = mem_wdata;
            wcount[mem_addr] = wcount[mem_addr] + 1;
            cool = H - 1;
         end
      end
   end

   always @(negedge clk) mem_rdata <= mem[mem_addr];

   typedef struct {
      logic [15:0] rdata;
      int          lat;
      int          we_len;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ref_mem [0:65535];
   logic [15:0] last_rdata;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic we, input logic word,
                           input logic [15:0] addr, input logic [15:0] wdata);
      exp_t        e;
      logic [15:0] a1;
      a1 = addr + 16'd1;
      if (we) begin
         if (addr >= 16'h8000) ref_mem[addr] = wdata[7:0];
         if (word && a1 >= 16'h8000) ref_mem[a1] = wdata[15:8];
         e.rdata = last_rdata;
      end else begin
         e.rdata    = {word ? ref_mem[a1] : 8'h00, ref_mem[addr]};
         last_rdata = e.rdata;
      end
      e.lat    = word ? 2 * H + 1 : H + 1;
      e.we_len = we ? (word ? 2 * H : H) : 0;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag, input int lat, input int we_len);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, {16'h0, rdata}, {16'h0, e.rdata});
         chk({tag, "_lat"}, lat, e.lat);
         if (we_len >= 0) chk({tag, "_we_len"}, we_len, e.we_len);
      end
   endtask

   task automatic access(input string tag, input logic we, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int pulse_at);
      int n;
      int wl;
      push_exp(we, word, addr, wdata);
      @(negedge clk);
      req = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n  = 1;
      wl = 0;
      while (n < 40) begin
         if (mem_write_en) wl++;
         if (ack) break;
         if (n == pulse_at) begin
            req = 1'b1; req_we = 1'b1; req_word = 1'b0;
            req_addr = 16'h8100; req_wdata = 16'h0077;
         end else begin
            req = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      req = 1'b0;
      if (!ack) chk({tag, "_timeout"}, 32'd0, 32'd1);
      pop_check(tag, n, wl);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (ack) return;
      end
      n = -1;
   endtask

   int n;
   int acks;

   initial begin
      reset = 1'b1;
      req = 1'b0; req_we = 1'b0; req_word = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
      last_rdata = 16'h0000;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_we", mem_write_en, 0);
      reset = 1'b0;

      access("bst", 1, 0, 16'h8010, 16'h005a, 0);
      access("bld", 0, 0, 16'h8010, 16'h0000, 0);
      chk("bst_once", wcount[16'h8010], 1);

      access("wst", 1, 1, 16'h9000, 16'hbeef, 0);
      access("wld", 0, 1, 16'h9000, 16'h0000, 0);
      chk("wst_lo", mem[16'h9000], 8'hef);
      chk("wst_hi", mem[16'h9001], 8'hbe);

      access("io_wst", 1, 1, 16'hfff9, 16'h1234, 0);
      chk("io_lo_once", wcount[16'hfff9], 1);
      chk("io_hi_once", wcount[16'hfffa], 1);
      chk("io_lo_val", mem[16'hfff9], 8'h34);
      chk("io_hi_val", mem[16'hfffa], 8'h12);

      access("uart", 1, 0, 16'hffe4, 16'h0003, 0);
      chk("uart_once", wcount[16'hffe4], 1);

      access("wrap_ld", 0, 1, 16'hffff, 16'h0000, 0);
      access("rom_ld", 0, 0, 16'h0005, 16'h0000, 0);
      access("rom_st", 1, 0, 16'h0100, 16'h00ff, 0);
      access("rom_rd", 0, 0, 16'h0100, 16'h0000, 0);

      access("pulse", 0, 0, 16'h8010, 16'h0000, 2);
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy) acks++;
      end
      chk("pulse_no_busy", acks, 0);
      chk("pulse_no_write", wcount[16'h8100], 0);

      // req held high across three accesses
      @(negedge clk);
      push_exp(0, 0, 16'h9000, 16'h0000);
      req = 1'b1; req_we = 1'b0; req_word = 1'b0; req_addr = 16'h9000; req_wdata = 16'h0;
      for (int k = 0; k < 3; k++) begin
         wait_ack(n);
         pop_check("b2b", (k == 0) ? n : n - 1, -1);
         if (k == 0) begin
            push_exp(1, 0, 16'h8020, 16'h0011);
            req_we = 1'b1; req_addr = 16'h8020; req_wdata = 16'h0011;
         end else if (k == 1) begin
            push_exp(0, 0, 16'h8020, 16'h0000);
            req_we = 1'b0; req_wdata = 16'h0;
         end else begin
            req = 1'b0;
         end
      end
      acks = 0;
      repeat (12) begin
         @(negedge clk);
         if (ack) acks++;
      end
      chk("b2b_no_extra", acks, 0);
      chk("b2b_st_once", wcount[16'h8020], 1);

      // reset during HI of a word store
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 16'h8200; req_wdata = 16'ha55a;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n = 1;
      while (n < 6) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_we", mem_write_en, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_rdata", rdata, 0);
      @(negedge clk);
      reset = 1'b0;
      last_rdata = 16'h0000;
      acks = 0;
      repeat (12) begin
         @(negedge clk);
         if (ack) acks++;
      end
      chk("mid_rst_no_ack", acks, 0);
      chk("mid_rst_lo_stands", mem[16'h8200], 8'h5a);
      chk("mid_rst_lo_once", wcount[16'h8200], 1);
      access("post_rst", 0, 0, 16'h8010, 16'h0000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
